// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-ported core-local memory.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch win after STREAK_MAX consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fet_req_i,
  input  logic [31:0] fet_addr_i,
  input  logic        fet_flush_i,
  output logic        fet_gnt_o,
  output logic        fet_rvalid_o,
  output logic [31:0] fet_rdata_o,
  input  logic        dat_req_i,
  input  logic        dat_we_i,
  input  logic [3:0]  dat_be_i,
  input  logic [31:0] dat_addr_i,
  input  logic [31:0] dat_wdata_i,
  output logic        dat_gnt_o,
  output logic        dat_rvalid_o,
  output logic [31:0] dat_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT_F, WAIT_D, WAIT_X} state_e;

  state_e state_q, state_d;
  logic   fr, arb, guard, fet_win, grant;

  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_bad_streak_max
    $error("mem_port_arbiter: STREAK_MAX must be in 1..15");
  end

  assign fr  = fet_req_i & ~fet_flush_i;
  // A response in IDLE is stale, so it does not open an extra window.
  assign arb = (state_q == IDLE) | mem_rvalid_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] SMAX = 4'(STREAK_MAX);

  logic [3:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (!fet_req_i || (grant && fet_win))
      streak_d = '0;
    else if (grant && !fet_win && streak_q != SMAX)
      streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  assign guard = (streak_q == SMAX);
`else
  assign guard = 1'b0;
`endif

  assign fet_win   = fr & (~dat_req_i | guard);
  assign mem_req_o = arb & (fr | dat_req_i);
  assign grant     = mem_req_o & mem_gnt_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (grant)
      state_d = fet_win ? WAIT_F : WAIT_D;
    else if (state_q != IDLE && mem_rvalid_i)
      state_d = IDLE;
    else if (state_q == WAIT_F && fet_flush_i)
      state_d = WAIT_X;
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (fet_win) begin
        mem_be_o   = 4'hF;
        mem_addr_o = fet_addr_i;
      end else begin
        mem_we_o    = dat_we_i;
        mem_be_o    = dat_be_i;
        mem_addr_o  = dat_addr_i;
        mem_wdata_o = dat_wdata_i;
      end
    end
    fet_gnt_o    = grant & fet_win;
    dat_gnt_o    = grant & ~fet_win;
    fet_rvalid_o = mem_rvalid_i & (state_q == WAIT_F) & ~fet_flush_i;
    dat_rvalid_o = mem_rvalid_i & (state_q == WAIT_D);
    fet_rdata_o  = mem_rdata_i;
    dat_rdata_o  = mem_rdata_i;
    busy_o       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard (STREAK_MAX = 2).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fet_req_i, fet_flush_i, fet_gnt_o, fet_rvalid_o;
  logic [31:0] fet_addr_i, fet_rdata_o;
  logic        dat_req_i, dat_we_i, dat_gnt_o, dat_rvalid_o;
  logic [3:0]  dat_be_i;
  logic [31:0] dat_addr_i, dat_wdata_i, dat_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  typedef enum {EXP_F, EXP_D, EXP_DROP} kind_e;
  typedef struct {kind_e kind; logic [31:0] data;} exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STREAK_MAX(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .fet_req_i(fet_req_i), .fet_addr_i(fet_addr_i), .fet_flush_i(fet_flush_i),
    .fet_gnt_o(fet_gnt_o), .fet_rvalid_o(fet_rvalid_o), .fet_rdata_o(fet_rdata_o),
    .dat_req_i(dat_req_i), .dat_we_i(dat_we_i), .dat_be_i(dat_be_i),
    .dat_addr_i(dat_addr_i), .dat_wdata_i(dat_wdata_i),
    .dat_gnt_o(dat_gnt_o), .dat_rvalid_o(dat_rvalid_o), .dat_rdata_o(dat_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    fet_req_i = 0; fet_addr_i = '0; fet_flush_i = 0;
    dat_req_i = 0; dat_we_i = 0; dat_be_i = '0; dat_addr_i = '0; dat_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  // Compare the response currently presented against the oldest expectation.
  task automatic sb_pop(input string tag);
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed empty expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    case (e.kind)
      EXP_F: begin
        check({tag, "_frv"}, fet_rvalid_o, 1);
        check({tag, "_drv"}, dat_rvalid_o, 0);
        check({tag, "_fdata"}, fet_rdata_o, e.data);
      end
      EXP_D: begin
        check({tag, "_frv"}, fet_rvalid_o, 0);
        check({tag, "_drv"}, dat_rvalid_o, 1);
        check({tag, "_ddata"}, dat_rdata_o, e.data);
      end
      default: begin
        check({tag, "_frv"}, fet_rvalid_o, 0);
        check({tag, "_drv"}, dat_rvalid_o, 0);
      end
    endcase
  endtask

  initial begin
    logic [5:0] exp_fet_order;
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_fet_order = 6'b100100;
`else
    exp_fet_order = 6'b000000;
`endif

    // Reset: all outputs low.
    idle();
    rst_i = 1;
    @(negedge clk);
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_fgnt", fet_gnt_o, 0);
    check("rst_dgnt", dat_gnt_o, 0);
    check("rst_frv", fet_rvalid_o, 0);
    check("rst_drv", dat_rvalid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_be", mem_be_o, 0);
    cyc();
    rst_i = 0;

    // Single fetch, zero-cycle grant, response two cycles later.
    fet_req_i = 1; fet_addr_i = 32'h0000_0100; mem_gnt_i = 1;
    #1;
    check("f1_req", mem_req_o, 1);
    check("f1_gnt", fet_gnt_o, 1);
    check("f1_dgnt", dat_gnt_o, 0);
    check("f1_addr", mem_addr_o, 32'h100);
    check("f1_be", mem_be_o, 4'hF);
    check("f1_we", mem_we_o, 0);
    check("f1_busy0", busy_o, 0);
    sb_q.push_back('{EXP_F, 32'h0000_0013});
    cyc();
    idle();
    #1;
    check("f1_busy1", busy_o, 1);
    check("f1_early", fet_rvalid_o, 0);
    cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    #1;
    check("f1_busy2", busy_o, 1);
    sb_pop("f1");
    cyc();
    idle();
    #1;
    check("f1_done", busy_o, 0);

    // Contention: store wins, fetch issues back-to-back with the store response.
    fet_req_i = 1; fet_addr_i = 32'h0000_0104;
    dat_req_i = 1; dat_we_i = 1; dat_be_i = 4'hF;
    dat_addr_i = 32'h0000_2000; dat_wdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1;
    #1;
    check("c_dgnt", dat_gnt_o, 1);
    check("c_fgnt", fet_gnt_o, 0);
    check("c_we", mem_we_o, 1);
    check("c_addr", mem_addr_o, 32'h2000);
    check("c_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    sb_q.push_back('{EXP_D, 32'h0});
    cyc();
    dat_req_i = 0; dat_we_i = 0;
    #1;
    check("c_hold_req", mem_req_o, 0);
    check("c_hold_fgnt", fet_gnt_o, 0);
    cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    #1;
    sb_pop("c_d");
    check("c_b2b_fgnt", fet_gnt_o, 1);
    check("c_b2b_addr", mem_addr_o, 32'h104);
    check("c_b2b_we", mem_we_o, 0);
    sb_q.push_back('{EXP_F, 32'h0000_0297});
    cyc();
    idle();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0297;
    #1;
    sb_pop("c_f");
    cyc();
    idle();
    #1;
    check("c_done", busy_o, 0);

    // Flush one cycle after a fetch grant; late response is dropped.
    fet_req_i = 1; fet_addr_i = 32'h0000_0200; mem_gnt_i = 1;
    #1;
    check("x_gnt", fet_gnt_o, 1);
    sb_q.push_back('{EXP_F, 32'h0000_0011});
    cyc();
    idle();
    fet_flush_i = 1;
    #1;
    sb_q[0].kind = EXP_DROP;
    check("x_flush_frv", fet_rvalid_o, 0);
    check("x_flush_busy", busy_o, 1);
    cyc();
    fet_flush_i = 0;
    #1;
    check("x_wait_busy", busy_o, 1);
    cyc();
    #1;
    check("x_wait2_busy", busy_o, 1);
    cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0011;
    #1;
    sb_pop("x_resp");
    cyc();
    idle();
    #1;
    check("x_done", busy_o, 0);

    // Flush coincident with the fetch response.
    fet_req_i = 1; fet_addr_i = 32'h0000_0300; mem_gnt_i = 1;
    #1;
    check("xc_gnt", fet_gnt_o, 1);
    sb_q.push_back('{EXP_F, 32'h0000_0022});
    cyc();
    fet_flush_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0022;
    #1;
    sb_q[0].kind = EXP_DROP;
    sb_pop("xc_resp");
    check("xc_fgnt", fet_gnt_o, 0);
    check("xc_req", mem_req_o, 0);
    cyc();
    idle();
    #1;
    check("xc_done", busy_o, 0);

    // Both requesters held: observe grant order over six back-to-back issues.
    fet_req_i = 1; fet_addr_i = 32'h0000_0400;
    dat_req_i = 1; dat_we_i = 0; dat_be_i = 4'hF; dat_addr_i = 32'h0000_3000;
    mem_gnt_i = 1;
    for (int i = 0; i < 6; i++) begin
      mem_rvalid_i = (i > 0);
      mem_rdata_i  = 32'(32'h100 + i - 1);
      #1;
      if (i > 0) sb_pop($sformatf("s%0d", i));
      check($sformatf("s_order%0d", i), {30'b0, fet_gnt_o, dat_gnt_o},
            exp_fet_order[i] ? 32'd2 : 32'd1);
      sb_q.push_back('{exp_fet_order[i] ? EXP_F : EXP_D, 32'(32'h100 + i)});
      cyc();
    end
    idle();
    mem_rvalid_i = 1; mem_rdata_i = 32'h105;
    #1;
    sb_pop("s6");
    cyc();
    idle();
    #1;
    check("s_done", busy_o, 0);

    // Asynchronous reset in WAIT_D, then a late response.
    dat_req_i = 1; dat_we_i = 0; dat_be_i = 4'hF; dat_addr_i = 32'h0000_4000; mem_gnt_i = 1;
    #1;
    check("r_dgnt", dat_gnt_o, 1);
    sb_q.push_back('{EXP_D, 32'h55});
    cyc();
    idle();
    #1;
    check("r_busy", busy_o, 1);
    rst_i = 1;
    #1;
    check("r_busy_drop", busy_o, 0);
    sb_q.delete();
    cyc();
    rst_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    #1;
    check("r_late_drv", dat_rvalid_o, 0);
    check("r_late_frv", fet_rvalid_o, 0);
    check("r_late_busy", busy_o, 0);
    cyc();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
